// File: rtl/axis_pattern_checker_if.sv
// APB CSR port and AXI4-Stream sink port of axis_pattern_checker.
interface axis_pattern_checker_if #(
  parameter int APB_AW          = 32,
  parameter int APB_DW          = 32,
  parameter int AXIS_WIDTH_DATA = 32,
  parameter int AXIS_WIDTH_DS   = AXIS_WIDTH_DATA/8
);
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [APB_AW-1:0]          PADDR;
  logic [APB_DW-1:0]          PWDATA;
  logic [APB_DW/8-1:0]        PSTRB;
  logic [2:0]                 PPROT;
  logic [APB_DW-1:0]          PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;
  logic                       AXIS_TVALID;
  logic                       AXIS_TREADY;
  logic [AXIS_WIDTH_DATA-1:0] AXIS_TDATA;
  logic [AXIS_WIDTH_DS-1:0]   AXIS_TSTRB;
  logic                       AXIS_TLAST;
  logic                       AXIS_TSTART;
  logic                       IRQ;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output AXIS_TVALID, AXIS_TDATA, AXIS_TSTRB, AXIS_TLAST,
    output AXIS_TSTART,
    input  PRDATA, PREADY, PSLVERR, AXIS_TREADY, IRQ
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  AXIS_TVALID, AXIS_TDATA, AXIS_TSTRB, AXIS_TLAST,
    input  AXIS_TSTART,
    output PRDATA, PREADY, PSLVERR, AXIS_TREADY, IRQ
  );
endinterface

// File: rtl/axis_pattern_checker.sv
// AXI4-Stream incrementing-pattern checker with APB CSRs.
// Optional AXIS_PATTERN_CHECKER_BACKPRESSURE_EN adds LFSR-driven TREADY stalls.
module axis_pattern_checker #(
  parameter int          APB_AW          = 32,
  parameter int          APB_DW          = 32,
  parameter int          AXIS_WIDTH_DATA = 32,
  parameter int          AXIS_WIDTH_DS   = AXIS_WIDTH_DATA/8,
  parameter logic [31:0] VERSION         = 32'h2019_0410
) (
  input logic                   PCLK,
  input logic                   PRESETn,
  axis_pattern_checker_if.slave bus
);
  localparam int          DS   = AXIS_WIDTH_DS;
  localparam logic [7:0]  DS8  = 8'(DS);
  localparam logic [16:0] DS17 = 17'(DS);
  localparam logic [32:0] DS33 = 33'(DS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic        irq_en_q, en_q, go_q;
  logic [15:0] pkt_q, num_q, frm_cnt_q, pkt_off_q;
  logic [31:0] frame_q, frm_off_q, beat_q;
  logic [4:0]  status_q, status_d;
  logic [31:0] cnt_byte_q, cnt_pkt_q, cnt_err_q, first_err_q;
  logic [7:0]  pat_q;
  logic [31:0] prdata_q;
  logic        pslverr_q, tready_q, irq_q;
  logic        tready, bp_en;

  logic [7:0]  addr;
  logic [31:0] rdata;
  logic        mapped, setup, access, wr;
  logic        wr_ctrl, wr_pkt, wr_frm, wr_num, wr_stat;
  logic        start, zero_go, abort;

  logic        acc, data_err, start_err, last_err, strb_err, any_err;
  logic        pkt_end, frm_end;
  logic [16:0] pkt_nxt;
  logic [32:0] frm_nxt;
  logic        unused_ok;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign addr   = bus.PADDR[7:0];
  assign setup  = bus.PSEL & ~bus.PENABLE;
  assign access = bus.PSEL & bus.PENABLE;
  assign wr     = access & bus.PWRITE & mapped;

  assign wr_ctrl = wr & (addr == 8'h10);
  assign wr_pkt  = wr & (addr == 8'h20);
  assign wr_frm  = wr & (addr == 8'h24);
  assign wr_num  = wr & (addr == 8'h30);
  assign wr_stat = wr & (addr == 8'h40);

  assign start   = (state_q == IDLE) & wr_num & bus.PWDATA[31]
                 & en_q & (bus.PWDATA[15:0] != 16'd0);
  assign zero_go = (state_q == IDLE) & wr_num & bus.PWDATA[31]
                 & (bus.PWDATA[15:0] == 16'd0);
  assign abort   = (state_q == RUN)
                 & ((wr_num & ~bus.PWDATA[31]) | (wr_ctrl & ~bus.PWDATA[0]));

  always_comb begin
    mapped = 1'b1;
    rdata  = '0;
    unique case (addr)
      8'h00: rdata = VERSION;
      8'h10: rdata = {irq_en_q, 22'd0, bp_en, 7'd0, en_q};
      8'h20: rdata = {16'd0, pkt_q};
      8'h24: rdata = frame_q;
      8'h30: rdata = {go_q, 15'd0, num_q};
      8'h40: rdata = {27'd0, status_q};
      8'h44: rdata = cnt_byte_q;
      8'h48: rdata = cnt_pkt_q;
      8'h4C: rdata = cnt_err_q;
      8'h50: rdata = first_err_q;
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    data_err = 1'b0;
    for (int i = 0; i < DS; i++) begin
      if (bus.AXIS_TDATA[8*i +: 8] != pat_q + 8'(i)) data_err = 1'b1;
    end
  end

  assign acc       = bus.AXIS_TVALID & tready;
  assign pkt_nxt   = {1'b0, pkt_off_q} + DS17;
  assign frm_nxt   = {1'b0, frm_off_q} + DS33;
  assign pkt_end   = pkt_nxt >= {1'b0, pkt_q};
  assign frm_end   = frm_nxt >= {1'b0, frame_q};
  assign start_err = bus.AXIS_TSTART != (pkt_off_q == 16'd0);
  assign last_err  = bus.AXIS_TLAST != pkt_end;
  assign strb_err  = bus.AXIS_TSTRB != '1;
  assign any_err   = data_err | start_err | last_err | strb_err;

  // Error bits are OR-ed in after the W1C so a fresh error always survives.
  always_comb begin
    status_d = status_q;
    if (wr_stat) status_d = status_q & ~bus.PWDATA[4:0];
    if (acc) status_d[4:1] = status_d[4:1]
                           | {strb_err, start_err, last_err, data_err};
    if (state_q == DONE || zero_go) status_d[0] = 1'b1;
    if (start) status_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      irq_en_q    <= 1'b0;
      en_q        <= 1'b0;
      go_q        <= 1'b0;
      pkt_q       <= '0;
      num_q       <= '0;
      frame_q     <= '0;
      status_q    <= '0;
      cnt_byte_q  <= '0;
      cnt_pkt_q   <= '0;
      cnt_err_q   <= '0;
      first_err_q <= '0;
      frm_cnt_q   <= '0;
      pkt_off_q   <= '0;
      frm_off_q   <= '0;
      beat_q      <= '0;
      pat_q       <= '0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      tready_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      status_q  <= status_d;
      irq_q     <= irq_en_q & status_q[0];
      pslverr_q <= setup & ~mapped;
      if (setup && !bus.PWRITE) prdata_q <= mapped ? rdata : '0;
      if (wr_ctrl) begin
        irq_en_q <= bus.PWDATA[31];
        en_q     <= bus.PWDATA[0];
      end
      if (wr_pkt) pkt_q <= bus.PWDATA[15:0];
      if (wr_frm) frame_q <= bus.PWDATA;
      unique case (state_q)
        IDLE: begin
          if (wr_num) num_q <= bus.PWDATA[15:0];
          if (start) begin
            state_q     <= RUN;
            tready_q    <= 1'b1;
            go_q        <= 1'b1;
            cnt_byte_q  <= '0;
            cnt_pkt_q   <= '0;
            cnt_err_q   <= '0;
            first_err_q <= '1;
            frm_cnt_q   <= '0;
            pkt_off_q   <= '0;
            frm_off_q   <= '0;
            beat_q      <= '0;
            pat_q       <= '0;
          end
        end
        RUN: begin
          if (acc) begin
            cnt_byte_q <= sat_add(cnt_byte_q, 32'(DS));
            if (pkt_end) cnt_pkt_q <= sat_add(cnt_pkt_q, 32'd1);
            if (any_err) cnt_err_q <= sat_add(cnt_err_q, 32'd1);
            if (data_err && first_err_q == '1) first_err_q <= beat_q;
            pkt_off_q <= (pkt_end | frm_end) ? '0 : pkt_nxt[15:0];
            if (frm_end) begin
              frm_off_q <= '0;
              beat_q    <= '0;
              pat_q     <= '0;
              frm_cnt_q <= frm_cnt_q + 16'd1;
            end else begin
              frm_off_q <= frm_nxt[31:0];
              beat_q    <= beat_q + 32'd1;
              pat_q     <= pat_q + DS8;
            end
          end
          if (abort) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            go_q     <= 1'b0;
            if (wr_num) num_q <= bus.PWDATA[15:0];
          end else if (acc && frm_end && (frm_cnt_q + 16'd1 == num_q)) begin
            state_q  <= DONE;
            tready_q <= 1'b0;
          end
        end
        DONE: begin
          go_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIS_PATTERN_CHECKER_BACKPRESSURE_EN
  logic        bp_en_q;
  logic [15:0] lfsr_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bp_en_q <= 1'b0;
      lfsr_q  <= 16'hACE1;
    end else begin
      if (wr_ctrl) bp_en_q <= bus.PWDATA[8];
      if (start) lfsr_q <= 16'hACE1;
      else lfsr_q <= {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bp_en  = bp_en_q;
  assign tready = tready_q & (~bp_en_q | (lfsr_q[1:0] != 2'b00));
`else
  assign bp_en  = 1'b0;
  assign tready = tready_q;
`endif

  assign bus.PRDATA      = prdata_q;
  assign bus.PREADY      = 1'b1;
  assign bus.PSLVERR     = pslverr_q;
  assign bus.AXIS_TREADY = tready;
  assign bus.IRQ         = irq_q;

  assign unused_ok = ^{bus.PSTRB, bus.PPROT, bus.PADDR[APB_AW-1:8]};
endmodule

// File: doc/axis_pattern_checker.md
Name: axis_pattern_checker

Overview:
- AXI4-Stream sink with APB CSR slave; the receiving end of the bench-side stream pusher.
- Accepts stream beats and checks them against the incrementing byte pattern: every lane starts at its lane index and each accepted beat adds AXIS_WIDTH_DS to every lane, modulo 256.
- Checks TSTART/TLAST placement against the programmed packet size and counts bytes, packets, frames and errors.
- Used as a loop-back target and checker in stream-DMA benches and on-board self-tests.

Parameters:
- APB_AW, 32, APB address width; only PADDR[7:0] is decoded.
- APB_DW, 32, APB data width; must be 32.
- AXIS_WIDTH_DATA, 32, TDATA width; 32, 64 or 128.
- AXIS_WIDTH_DS, AXIS_WIDTH_DATA/8, byte lanes per beat.
- VERSION, 32'h2019_0410, value of the VERSION CSR.

Ports:
- PCLK  in  1  single clock for both the APB and AXIS sides.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1  APB control.
- PADDR  in  APB_AW  APB address.
- PWDATA  in  APB_DW  APB write data.
- PSTRB  in  APB_DW/8  APB write strobes; ignored, full-word writes only.
- PPROT  in  3  APB protection; ignored.
- PRDATA  out  APB_DW  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error response.
- AXIS_TVALID  in  1  stream valid.
- AXIS_TREADY  out  1  stream ready.
- AXIS_TDATA  in  AXIS_WIDTH_DATA  stream data.
- AXIS_TSTRB  in  AXIS_WIDTH_DS  stream byte strobes.
- AXIS_TLAST  in  1  end of packet.
- AXIS_TSTART  in  1  start of packet.
- IRQ  out  1  level interrupt.

Behaviour:
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, AXIS_TREADY=0, IRQ=0. All CSRs reset to 0 except VERSION.
- APB timing: zero wait states; PREADY is tied to 1. PRDATA is registered on the setup-phase edge (PSEL & !PENABLE & !PWRITE) and holds until the next read. Writes take effect on the access-phase edge.
- APB errors: PSLVERR=1 in the access phase for an unmapped address. An erroring write has no effect; an erroring read returns 0.
- CSR map:
  - 0x00 VERSION (RO).
  - 0x10 CONTROL: [31] irq_en, [0] en.
  - 0x20 PACKET: [15:0] bytes per packet, a multiple of AXIS_WIDTH_DS and nonzero.
  - 0x24 FRAME: bytes per frame, a multiple of PACKET.
  - 0x30 NUM: [31] go, [15:0] frames to receive.
  - 0x40 STATUS: [0] done, [1] data_err, [2] last_err, [3] start_err, [4] strb_err. W1C.
  - 0x44 CNT_BYTE, 0x48 CNT_PKT, 0x4C CNT_ERR (RO). All saturate at 0xFFFF_FFFF.
  - 0x50 FIRST_ERR (RO): beat index within the frame of the first mismatch; 0xFFFF_FFFF when no error.
- State IDLE:
  - TREADY=0.
  - A write to NUM with go=1, en=1 and NUM[15:0]!=0 clears all counters, STATUS and FIRST_ERR, loads the pattern, then moves to RUN.
  - go=1 with NUM[15:0]=0 sets done immediately and stays in IDLE.
- State RUN:
  - TREADY=1 (subject to the optional feature). A beat is accepted on TVALID & TREADY.
  - Per accepted beat, in the same cycle: compare each lane against the expected pattern; TSTART must equal (byte offset in packet == 0); TLAST must equal (offset == PACKET-DS); TSTRB must be all ones.
  - Each failing check sets its STATUS bit and increments CNT_ERR by 1 per beat, not per lane.
  - CNT_BYTE += DS per accepted beat; CNT_PKT += 1 on the packet's final beat as counted by offset, independent of TLAST.
  - When the frame byte offset reaches FRAME, the pattern reloads to lane indices and the frame count increments.
  - When the frame count reaches NUM[15:0]: go to DONE; TREADY falls on the next cycle.
- State DONE: set STATUS.done and clear NUM.go, then return to IDLE.
- Go bit readback: NUM.go reads 1 throughout RUN.
- Abort: a NUM write with go=0 during RUN returns to IDLE next cycle, counters are kept and done is not set. Clearing CONTROL.en during RUN has the same effect.
- Go while busy: a go=1 write during RUN is ignored.
- Same-cycle events: if a W1C of STATUS and a new error occur in the same cycle, the new error wins.
- IRQ = irq_en & STATUS.done, registered; it clears one cycle after the W1C of done.

Optional Feature:
- Macro: AXIS_PATTERN_CHECKER_BACKPRESSURE_EN.
- Defined: adds a 16-bit LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, reseeded on go) and CONTROL[8] bp_en. In RUN with bp_en=1, TREADY = LFSR[1:0]!=0, so roughly 25% of cycles are stalled. The LFSR advances every cycle.
- Undefined: CONTROL[8] reads 0 and TREADY=1 throughout RUN.

Test Plan:
- Reset, then read VERSION, CONTROL, PACKET and 0x60 -> 0x2019_0410, 0, 0, and PSLVERR=1 with PRDATA=0 on 0x60.
- CONTROL=0x8000_0001, PACKET=0x40, FRAME=0x400, NUM=0x8000_0001; push one 1 KB frame with random TVALID gaps -> NUM.go clears, STATUS=0x1, CNT_BYTE=0x400, CNT_PKT=16, CNT_ERR=0, IRQ=1; a W1C of 0x1 clears IRQ.
- NUM=0x8000_0003; push 3 frames back-to-back -> CNT_PKT=48, CNT_BYTE=0xC00, and the pattern restarts at 0x03020100 on each frame.
- Corrupt lane 2 of beat 5 in frame 0 -> STATUS[1]=1, CNT_ERR=1, FIRST_ERR=5, and done is still set at the end.
- Drop TLAST on the final beat of packet 3 and assert TSTART mid-packet once -> STATUS[2] and STATUS[3] set, CNT_ERR=2, CNT_PKT unaffected (16).
- Abort with a go=0 write after 10 beats -> TREADY=0 next cycle, CNT_BYTE=40, done=0. With the backpressure macro defined and bp_en=1, the 1 KB frame still passes with at least one TREADY=0 cycle observed.
